// File: rtl/counter_rx_pkg.sv
// ============================================================================
// Module  : counter_rx_pkg
// Purpose : Shared types, defaults and helpers for the counter frame receiver.
//           Optional macro OVF_TAG_EN adds an overflow tag bit to stored words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_t;

  localparam int DEF_NUM_CH  = 8;
  localparam int DEF_COUNT_W = 16;
  localparam int DEF_ADDR_W  = 4;
  localparam int MAX_CH      = 16;

`ifdef OVF_TAG_EN
  localparam int TAG_W = 1;
`else
  localparam int TAG_W = 0;
`endif

  // Mask with the low n bits set: the sweep is complete when it equals this.
  function automatic logic [MAX_CH-1:0] sweep_full_mask(input int n);
    logic [MAX_CH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_rx_regfile.sv
// ============================================================================
// Module  : counter_rx_regfile
// Purpose : Per-channel count storage, one write port, combinational read
//           returning zero for addresses beyond the channel count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_rx_regfile #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (we && (waddr == ADDR_W'(i))) mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (raddr == ADDR_W'(i)) rdata = mem[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_frame_receiver.sv
// ============================================================================
// Module  : counter_frame_receiver
// Purpose : Deserializes MSB-first count words from the impulse counter link
//           into a per-channel register file; flags framing errors and sweeps.
//           Optional macro OVF_TAG_EN stores the overflow flag as a tag MSB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_frame_receiver
  import counter_rx_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     sl_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     ovf_in,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [COUNT_W+TAG_W-1:0] rd_data,
  output logic                     word_valid,
  output logic [ADDR_W-1:0]        word_ch,
  output logic [COUNT_W+TAG_W-1:0] word_data,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int DATA_W = COUNT_W + TAG_W;
  localparam int SHW    = COUNT_W - 1;
  localparam int CNT_W  = $clog2(COUNT_W + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(COUNT_W - 1);
  localparam logic [ADDR_W:0]   NUM_CH_X  = (ADDR_W + 1)'(NUM_CH);
  localparam logic [MAX_CH-1:0] FULL_EXT  = sweep_full_mask(NUM_CH);
  localparam logic [NUM_CH-1:0] FULL_MASK = FULL_EXT[NUM_CH-1:0];

  rx_state_t          state;
  logic [SHW-1:0]     shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [ADDR_W-1:0]  ch_q;
  logic [NUM_CH-1:0]  sweep_mask;

  logic [COUNT_W-1:0] w_word;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_shift_ok;
  logic               w_last;
  logic               w_in_range;
  logic               w_we;
  logic [NUM_CH-1:0]  w_ch_bit;
  logic [NUM_CH-1:0]  w_mask_or;

  assign w_word     = {shreg, serial_in};
  assign w_shift_ok = (state == SHIFT) && !sl_in && (addr_in == ch_q);
  assign w_last     = (bit_cnt == LAST_CNT);
  assign w_in_range = ({1'b0, ch_q} < NUM_CH_X);
  assign w_we       = w_shift_ok && w_last && w_in_range;
  assign w_ch_bit   = NUM_CH'(1) << ch_q;
  assign w_mask_or  = sweep_mask | w_ch_bit;

`ifdef OVF_TAG_EN
  assign w_wdata = {ovf_in, w_word};
`else
  logic unused_ovf;
  assign unused_ovf = ovf_in;
  assign w_wdata    = w_word;
`endif

  counter_rx_regfile #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .waddr (ch_q),
    .wdata (w_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      ch_q       <= '0;
      sweep_mask <= '0;
      word_valid <= 1'b0;
      word_ch    <= '0;
      word_data  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (sl_in) state <= LOAD;
        end
        LOAD: begin
          bit_cnt <= '0;
          if (!sl_in) begin
            ch_q    <= addr_in;
            shreg   <= SHW'(serial_in);
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sl_in) begin
            frame_err <= 1'b1;
            state     <= LOAD;
          end else if (addr_in != ch_q) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            shreg   <= w_word[SHW-1:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (w_last) begin
              state <= HOLD;
              if (w_in_range) begin
                word_valid <= 1'b1;
                word_ch    <= ch_q;
                word_data  <= w_wdata;
                // A repeated channel starts a fresh sweep from that channel.
                if ((sweep_mask & w_ch_bit) != '0) begin
                  sweep_mask <= w_ch_bit;
                end else if (w_mask_or == FULL_MASK) begin
                  sweep_mask <= '0;
                  frame_done <= 1'b1;
                end else begin
                  sweep_mask <= w_mask_or;
                end
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (sl_in) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_frame_receiver.sv
// ============================================================================
// Module  : tb_counter_frame_receiver
// Purpose : Directed and randomized checks of counter_frame_receiver against a
//           channel-array / seen-set reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_counter_frame_receiver;

  localparam int NCH = 8;
  localparam int CW  = 16;
  localparam int TW  = counter_rx_pkg::TAG_W;
  localparam int DW  = CW + TW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          serial_in = 1'b0;
  logic          sl_in = 1'b0;
  logic [3:0]    addr_in = '0;
  logic          ovf_in = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          word_valid;
  logic [3:0]    word_ch;
  logic [DW-1:0] word_data;
  logic          frame_done;
  logic          frame_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_rf [NCH];
  bit          m_seen [NCH];

  always #50 clk = ~clk;

  counter_frame_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .sl_in      (sl_in),
    .addr_in    (addr_in),
    .ovf_in     (ovf_in),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .word_valid (word_valid),
    .word_ch    (word_ch),
    .word_data  (word_data),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_rf[i]   = '0;
      m_seen[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_rd(input int a);
    return (a < NCH) ? m_rf[a] : 32'h0;
  endfunction

  // Store a word in the model; returns whether this store completes a sweep.
  function automatic bit model_store(input int ch, input logic [31:0] v);
    int n;
    m_rf[ch] = v;
    if (m_seen[ch]) begin
      for (int i = 0; i < NCH; i++) m_seen[i] = 1'b0;
      m_seen[ch] = 1'b1;
      return 1'b0;
    end
    m_seen[ch] = 1'b1;
    n = 0;
    for (int i = 0; i < NCH; i++) n += int'(m_seen[i]);
    if (n == NCH) begin
      for (int i = 0; i < NCH; i++) m_seen[i] = 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk_pulses(input string tag, input bit v, input bit d, input bit e);
    chk(tag, {29'b0, word_valid, frame_done, frame_err}, {29'b0, v, d, e});
  endtask

  task automatic check_rd_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk(tag, 32'(rd_data), model_rd(a));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  // Load pulse then nbits MSB-first bits on channel ch; nbits < CW ends short.
  task automatic send_frame(input int ch, input logic [15:0] val, input int nbits, input bit ovf);
    logic [31:0] exp;
    bit          exp_done;
    sl_in   = 1'b1;
    addr_in = 4'(ch);
    tick();
    chk_pulses("load_quiet", 1'b0, 1'b0, 1'b0);
    rd_addr = 4'(ch);
    for (int i = 0; i < nbits; i++) begin
      sl_in     = 1'b0;
      serial_in = val[CW-1-i];
      ovf_in    = (i == nbits - 1) ? ovf : ~ovf;
      if (i == CW - 1) chk("rd_before_write", 32'(rd_data), model_rd(ch));
      tick();
      if (i < CW - 1) chk_pulses("shift_quiet", 1'b0, 1'b0, 1'b0);
    end
    if (nbits < CW) begin
      sl_in = 1'b1;
      tick();
      chk_pulses("short_err", 1'b0, 1'b0, 1'b1);
      chk("short_rd_kept", 32'(rd_data), model_rd(ch));
    end else if (ch < NCH) begin
      exp = 32'(val) | ((TW != 0 && ovf) ? 32'h10000 : 32'h0);
      exp_done = model_store(ch, exp);
      chk_pulses("word_pulses", 1'b1, exp_done, 1'b0);
      chk("word_ch", 32'(word_ch), 32'(ch));
      chk("word_data", 32'(word_data), exp);
      chk("rd_after_write", 32'(rd_data), exp);
    end else begin
      chk_pulses("range_err", 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Address changes from ch_a to ch_b while sampling bit at_bit.
  task automatic send_addr_change(input int ch_a, input int ch_b, input int at_bit);
    sl_in   = 1'b1;
    addr_in = 4'(ch_a);
    tick();
    for (int i = 0; i <= at_bit; i++) begin
      sl_in     = 1'b0;
      serial_in = 1'($urandom);
      addr_in   = (i == at_bit) ? 4'(ch_b) : 4'(ch_a);
      tick();
    end
    chk_pulses("addr_err", 1'b0, 1'b0, 1'b1);
    // Back in IDLE: shift-phase activity must be ignored.
    for (int i = 0; i < 3; i++) begin
      serial_in = 1'($urandom);
      tick();
    end
    chk_pulses("idle_quiet", 1'b0, 1'b0, 1'b0);
    rd_addr = 4'(ch_a);
    #1;
    chk("addr_err_rd", 32'(rd_data), model_rd(ch_a));
  endtask

  initial begin
    int kind, ch, nb;
    model_clear();
    tick();
    chk_pulses("reset_pulses", 1'b0, 1'b0, 1'b0);
    chk("reset_word_ch", 32'(word_ch), 32'h0);
    chk("reset_word_data", 32'(word_data), 32'h0);
    check_rd_all("reset_rd");
    reset = 1'b0;

    send_frame(3, 16'hA5C3, CW, 1'b0);
    check_rd_all("a5c3_rd");

    send_frame(2, 16'h1234, 9, 1'b0);
    send_frame(2, 16'h0001, CW, 1'b0);

    send_addr_change(4, 5, 6);

    // Reset in the middle of a word after earlier stores.
    sl_in   = 1'b1;
    addr_in = 4'd1;
    tick();
    for (int i = 0; i < 10; i++) begin
      sl_in     = 1'b0;
      serial_in = 1'($urandom);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk_pulses("midreset_pulses", 1'b0, 1'b0, 1'b0);
    chk("midreset_word_ch", 32'(word_ch), 32'h0);
    chk("midreset_word_data", 32'(word_data), 32'h0);
    check_rd_all("midreset_rd");
    tick();
    reset = 1'b0;
    send_frame(1, 16'hBEEF, CW, 1'b1);

    do_reset();
    for (int n = 0; n < NCH; n++) send_frame(n, 16'h1000 + 16'(n), CW, 1'b0);
    check_rd_all("sweep_rd");
    for (int n = 0; n < 4; n++) send_frame(n, 16'(($urandom)), CW, 1'b0);
    send_frame(0, 16'h7777, CW, 1'b0);
    for (int n = 1; n < NCH; n++) send_frame(n, 16'(($urandom)), CW, 1'b0);

    send_frame(6, 16'hFFFF, CW, 1'b1);
    send_frame(6, 16'hFFFF, CW, 1'b0);

    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 9));
      ch   = int'($urandom_range(0, NCH - 1));
      if (kind < 6) begin
        send_frame(ch, 16'($urandom), CW, 1'($urandom));
      end else if (kind == 6) begin
        send_frame(int'($urandom_range(NCH, 15)), 16'($urandom), CW, 1'($urandom));
      end else if (kind == 7) begin
        nb = int'($urandom_range(1, CW - 1));
        send_frame(ch, 16'($urandom), nb, 1'b0);
      end else begin
        send_addr_change(ch, (ch + int'($urandom_range(1, 15))) % 16,
                         int'($urandom_range(1, CW - 1)));
      end
    end
    check_rd_all("final_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
